// File: rtl/barrett_final_correct.sv
// Final correction stage of the Barrett reducer: two conditional subtractions of p,
// pipelined over two registers with valid/ready backpressure and a global clock enable.
module barrett_final_correct #(
    parameter int R_WIDTH   = 51,
    parameter int M_WIDTH   = 25,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic [M_WIDTH-1:0]   P,
    input  logic [R_WIDTH-1:0]   R_IN,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [M_WIDTH-1:0]   RES,
    output logic                 RES_ERR,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [CNT_WIDTH-1:0] RES_COUNT,
    output logic [CNT_WIDTH-1:0] ERR_COUNT
);

    // Subtract m when the difference stays non-negative, else pass v through.
    function automatic logic [R_WIDTH-1:0] cond_sub(input logic [R_WIDTH-1:0] v,
                                                    input logic [M_WIDTH-1:0] m);
        logic signed [R_WIDTH:0] d;
        d = $signed({1'b0, v}) - $signed({{(R_WIDTH+1-M_WIDTH){1'b0}}, m});
        return (d < 0) ? v : d[R_WIDTH-1:0];
    endfunction

    // A selection still >= p means the raw remainder was outside [0, 3p).
    function automatic logic not_canonical(input logic [R_WIDTH-1:0] v,
                                           input logic [M_WIDTH-1:0] m);
        return v >= {{(R_WIDTH-M_WIDTH){1'b0}}, m};
    endfunction

    logic [R_WIDTH-1:0]   s1_p1;
    logic                 vld_p1;
    logic [R_WIDTH-1:0]   sel_p1;
    logic [M_WIDTH-1:0]   res_p2;
    logic                 err_p2;
    logic                 vld_p2;
    logic                 adv1;
    logic                 adv2;
    logic                 fire;
    logic [CNT_WIDTH-1:0] res_cnt;
    logic [CNT_WIDTH-1:0] err_cnt;

    always_comb begin
        adv2   = CE & (~vld_p2 | OUT_READY);
        adv1   = CE & (~vld_p1 | adv2);
        fire   = vld_p2 & OUT_READY & CE;
        sel_p1 = cond_sub(s1_p1, P);
    end

    assign IN_READY  = adv1;
    assign OUT_VALID = vld_p2;
    assign RES       = res_p2;
    assign RES_ERR   = err_p2;
    assign RES_COUNT = res_cnt;
    assign ERR_COUNT = err_cnt;

    // Stage 1 boundary: first conditional subtraction
    always_ff @(posedge CLK) begin
        if (CE && adv1 && IN_VALID) begin
            s1_p1 <= cond_sub(R_IN, P);
        end
    end

    // Stage 2 boundary: second subtraction, output register and delivery counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            res_p2  <= '0;
            err_p2  <= 1'b0;
            res_cnt <= '0;
            err_cnt <= '0;
        end else if (CE) begin
            if (adv1) begin
                vld_p1 <= IN_VALID;
            end
            if (adv2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    res_p2 <= sel_p1[M_WIDTH-1:0];
                    err_p2 <= not_canonical(sel_p1, P);
                end
            end
            if (fire) begin
                res_cnt <= res_cnt + CNT_WIDTH'(1);
                if (err_p2) begin
                    err_cnt <= err_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_barrett_final_correct.sv
// Randomized and directed bench for barrett_final_correct against a quotient-based reference.
module tb_barrett_final_correct;

    localparam int RW = 51;
    localparam int MW = 25;
    localparam int CW = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          CE = 1'b1;
    logic [MW-1:0] P = 25'd17;
    logic [RW-1:0] R_IN = '0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [MW-1:0] RES;
    logic          RES_ERR;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b1;
    logic [CW-1:0] RES_COUNT;
    logic [CW-1:0] ERR_COUNT;

    barrett_final_correct #(.R_WIDTH(RW), .M_WIDTH(MW), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .P(P), .R_IN(R_IN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .RES(RES), .RES_ERR(RES_ERR),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .RES_COUNT(RES_COUNT), .ERR_COUNT(ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: Barrett final correction subtracts min(floor(r/p), 2) multiples of p.
    function automatic logic [MW:0] ref_reduce(input longint unsigned r, input longint unsigned p);
        longint unsigned k;
        longint unsigned sel;
        logic [MW-1:0]   res;
        k = r / p;
        if (k > 2) k = 2;
        sel = r - k * p;
        res = sel[MW-1:0];
        return {sel >= p, res};
    endfunction

    logic [MW:0]   exp_q[$];
    longint unsigned exp_res_cnt = 0;
    longint unsigned exp_err_cnt = 0;
    logic          held_valid = 1'b0;
    logic [MW-1:0] held_res;
    logic          held_err;

    // Transaction monitor: inputs are driven after posedge, so the handshakes are settled here.
    always @(negedge CLK) begin
        logic [MW:0] e;
        if (RST) begin
            exp_q.delete();
            exp_res_cnt = 0;
            exp_err_cnt = 0;
            held_valid  = 1'b0;
        end else begin
            if (held_valid) begin
                check("hold_res", 64'(RES), 64'(held_res));
                check("hold_err", 64'(RES_ERR), 64'(held_err));
            end
            if (OUT_VALID && OUT_READY && CE) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("res", 64'(RES), 64'(e[MW-1:0]));
                    check("res_err", 64'(RES_ERR), 64'(e[MW]));
                    exp_res_cnt = (exp_res_cnt + 1) % (64'd1 << CW);
                    if (e[MW]) exp_err_cnt = (exp_err_cnt + 1) % (64'd1 << CW);
                end
            end
            if (IN_VALID && IN_READY) begin
                exp_q.push_back(ref_reduce(longint'(R_IN), longint'(P)));
            end
            held_valid = OUT_VALID && !(OUT_READY && CE);
            held_res   = RES;
            held_err   = RES_ERR;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [RW-1:0] r);
        int t;
        IN_VALID = 1'b1;
        R_IN     = r;
        t = 0;
        while (!IN_READY && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) check("send_timeout", 64'(IN_READY), 64'(1));
        step();
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int t;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        CE        = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || OUT_VALID) && t < 200) begin
            step();
            t++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_res_count"}, 64'(RES_COUNT), 64'(exp_res_cnt));
        check({tag, "_err_count"}, 64'(ERR_COUNT), 64'(exp_err_cnt));
    endtask

    initial begin
        logic [RW-1:0] stream[6];
        logic [RW-1:0] big;
        logic [MW-1:0] frozen_res;
        logic          frozen_vld;
        longint unsigned frozen_cnt;
        stream = '{51'd0, 51'd16, 51'd17, 51'd33, 51'd34, 51'd50};

        // Reset state
        step(); step();
        check("rst_out_valid", 64'(OUT_VALID), 64'(0));
        check("rst_res", 64'(RES), 64'(0));
        check("rst_res_err", 64'(RES_ERR), 64'(0));
        check("rst_res_count", 64'(RES_COUNT), 64'(0));
        check("rst_err_count", 64'(ERR_COUNT), 64'(0));
        RST = 1'b0;
        #1;
        check("ready_after_rst", 64'(IN_READY), 64'(1));

        // Latency: accepted at edge n, visible after edge n+1
        IN_VALID = 1'b1;
        R_IN = 51'd50;
        step();
        IN_VALID = 1'b0;
        check("lat_not_yet", 64'(OUT_VALID), 64'(0));
        step();
        check("lat_valid", 64'(OUT_VALID), 64'(1));
        check("lat_res", 64'(RES), 64'(16));
        drain();

        // Back-to-back stream at full throughput
        for (int i = 0; i < 6; i++) begin
            IN_VALID = 1'b1;
            R_IN = stream[i];
            check("stream_ready", 64'(IN_READY), 64'(1));
            step();
        end
        IN_VALID = 1'b0;
        step();
        check("stream_last_valid", 64'(OUT_VALID), 64'(1));
        check("stream_last_res", 64'(RES), 64'(16));
        drain();
        check_counts("stream");
        check("stream_count_abs", 64'(RES_COUNT), 64'(7));

        // Out-of-range remainders
        send(51'd51);
        big = '1;
        send(big);
        drain();
        check_counts("err");
        check("err_count_abs", 64'(ERR_COUNT), 64'(2));

        // Backpressure: two entries fill the pipe, third waits
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        R_IN = 51'd40;
        step();
        R_IN = 51'd5;
        step();
        R_IN = 51'd20;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready_low", 64'(IN_READY), 64'(0));
            check("bp_res_held", 64'(RES), 64'(6));
            step();
        end
        OUT_READY = 1'b1;
        #1;
        check("bp_pass_through", 64'(IN_READY), 64'(1));
        step();
        IN_VALID = 1'b0;
        drain();
        check_counts("bp");

        // Clock-enable freeze mid-stream
        IN_VALID = 1'b1;
        R_IN = 51'd45;
        step();
        R_IN = 51'd8;
        step();
        IN_VALID = 1'b1;
        R_IN = 51'd30;
        CE = 1'b0;
        #1;
        frozen_res = RES;
        frozen_vld = OUT_VALID;
        frozen_cnt = longint'(RES_COUNT);
        for (int i = 0; i < 5; i++) begin
            check("ce_in_ready", 64'(IN_READY), 64'(0));
            step();
            check("ce_res_frozen", 64'(RES), 64'(frozen_res));
            check("ce_vld_frozen", 64'(OUT_VALID), 64'(frozen_vld));
            check("ce_cnt_frozen", 64'(RES_COUNT), 64'(frozen_cnt));
        end
        CE = 1'b1;
        #1;
        check("ce_resume_ready", 64'(IN_READY), 64'(1));
        step();
        IN_VALID = 1'b0;
        drain();
        check_counts("ce");

        // Reset with two entries in flight
        OUT_READY = 1'b0;
        send(51'd3);
        send(51'd4);
        RST = 1'b1;
        step();
        check("mid_rst_out_valid", 64'(OUT_VALID), 64'(0));
        check("mid_rst_res_count", 64'(RES_COUNT), 64'(0));
        check("mid_rst_err_count", 64'(ERR_COUNT), 64'(0));
        RST = 1'b0;
        OUT_READY = 1'b1;
        #1;
        check("post_rst_ready", 64'(IN_READY), 64'(1));
        send(51'd40);
        step();
        check("post_rst_res", 64'(RES), 64'(6));
        drain();
        check_counts("post_rst");

        // Randomized traffic with random moduli, backpressure and CE gaps
        for (int blk = 0; blk < 8; blk++) begin
            drain();
            P = (blk == 0) ? 25'd1 : MW'($urandom_range(1, (1 << MW) - 1));
            for (int c = 0; c < 150; c++) begin
                longint unsigned lim;
                lim = 3 * longint'(P);
                IN_VALID  = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) == 0)
                    R_IN = {$urandom, $urandom};
                else
                    R_IN = RW'(longint'({$urandom, $urandom}) % lim);
                OUT_READY = ($urandom_range(0, 3) != 0);
                CE        = ($urandom_range(0, 9) != 0);
                step();
            end
        end
        drain();
        check_counts("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
